// File: rtl/idm_ctrl_sequencer_pkg.sv
// Shared types, codes and twiddle schedule for the interdimensional multiplier sequencer.
// Lane k of row r is multiplied by W64^(r*k); the table splits r*k into octant (deshuf) and fine angle (type).
package idm_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned LANES = 8;

    typedef enum logic [1:0] {
        IDM_IDLE,
        IDM_RUN,
        IDM_DRAIN
    } idm_state_e;

    localparam logic [2:0] IDM_BYP_NONE = 3'd0;
    localparam logic [2:0] IDM_BYP_PASS = 3'd1;

    // Fine twiddle angle within an octant: W64^n for n = 0..7
    typedef enum logic [2:0] {
        IDM_TYPE_W0,
        IDM_TYPE_W1,
        IDM_TYPE_W2,
        IDM_TYPE_W3,
        IDM_TYPE_W4,
        IDM_TYPE_W5,
        IDM_TYPE_W6,
        IDM_TYPE_W7
    } idm_type_e;

    typedef struct packed {
        logic [2:0] shuf;
        logic [2:0] type_sel;
        logic [2:0] deshuf;
    } idm_sched_t;

    typedef struct packed {
        logic [23:0] shuf;
        logic [23:0] type_sel;
        logic [23:0] bypass_sel;
        logic [23:0] deshuf;
        logic [7:0]  bypass_en;
    } idm_ctrl_t;

    // Entry {shuf, type, deshuf}: shuf = k, type = (r*k) mod 8, deshuf = (r*k) div 8
    localparam idm_sched_t IDM_SCHED [ROWS][LANES] = '{
        '{'{3'd0,3'd0,3'd0}, '{3'd1,3'd0,3'd0}, '{3'd2,3'd0,3'd0}, '{3'd3,3'd0,3'd0}, '{3'd4,3'd0,3'd0}, '{3'd5,3'd0,3'd0}, '{3'd6,3'd0,3'd0}, '{3'd7,3'd0,3'd0}},
        '{'{3'd0,3'd0,3'd0}, '{3'd1,3'd1,3'd0}, '{3'd2,3'd2,3'd0}, '{3'd3,3'd3,3'd0}, '{3'd4,3'd4,3'd0}, '{3'd5,3'd5,3'd0}, '{3'd6,3'd6,3'd0}, '{3'd7,3'd7,3'd0}},
        '{'{3'd0,3'd0,3'd0}, '{3'd1,3'd2,3'd0}, '{3'd2,3'd4,3'd0}, '{3'd3,3'd6,3'd0}, '{3'd4,3'd0,3'd1}, '{3'd5,3'd2,3'd1}, '{3'd6,3'd4,3'd1}, '{3'd7,3'd6,3'd1}},
        '{'{3'd0,3'd0,3'd0}, '{3'd1,3'd3,3'd0}, '{3'd2,3'd6,3'd0}, '{3'd3,3'd1,3'd1}, '{3'd4,3'd4,3'd1}, '{3'd5,3'd7,3'd1}, '{3'd6,3'd2,3'd2}, '{3'd7,3'd5,3'd2}},
        '{'{3'd0,3'd0,3'd0}, '{3'd1,3'd4,3'd0}, '{3'd2,3'd0,3'd1}, '{3'd3,3'd4,3'd1}, '{3'd4,3'd0,3'd2}, '{3'd5,3'd4,3'd2}, '{3'd6,3'd0,3'd3}, '{3'd7,3'd4,3'd3}},
        '{'{3'd0,3'd0,3'd0}, '{3'd1,3'd5,3'd0}, '{3'd2,3'd2,3'd1}, '{3'd3,3'd7,3'd1}, '{3'd4,3'd4,3'd2}, '{3'd5,3'd1,3'd3}, '{3'd6,3'd6,3'd3}, '{3'd7,3'd3,3'd4}},
        '{'{3'd0,3'd0,3'd0}, '{3'd1,3'd6,3'd0}, '{3'd2,3'd4,3'd1}, '{3'd3,3'd2,3'd2}, '{3'd4,3'd0,3'd3}, '{3'd5,3'd6,3'd3}, '{3'd6,3'd4,3'd4}, '{3'd7,3'd2,3'd5}},
        '{'{3'd0,3'd0,3'd0}, '{3'd1,3'd7,3'd0}, '{3'd2,3'd6,3'd1}, '{3'd3,3'd5,3'd2}, '{3'd4,3'd4,3'd3}, '{3'd5,3'd3,3'd4}, '{3'd6,3'd2,3'd5}, '{3'd7,3'd1,3'd6}}
    };

endpackage

// File: rtl/idm_ctrl_sequencer_if.sv
// Row handshake and multiplier control bus between upstream, sequencer and twiddle multiplier.
interface idm_ctrl_sequencer_if;

    logic        start;
    logic        row_valid;
    logic        row_ready;
    logic [23:0] shuf_ctrl;
    logic [23:0] type_sel;
    logic [23:0] bypass_sel;
    logic [23:0] deshuf_ctrl;
    logic [7:0]  bypass_en;
    logic [7:0]  hold_ctrl;
    logic [7:0]  dff_ctrl;
    logic [2:0]  row_idx;
    logic        out_valid;
    logic        busy;
    logic        frame_done;

    modport master (
        output start, row_valid,
        input  row_ready, shuf_ctrl, type_sel, bypass_sel, deshuf_ctrl,
        input  bypass_en, hold_ctrl, dff_ctrl, row_idx, out_valid, busy, frame_done
    );

    modport slave (
        input  start, row_valid,
        output row_ready, shuf_ctrl, type_sel, bypass_sel, deshuf_ctrl,
        output bypass_en, hold_ctrl, dff_ctrl, row_idx, out_valid, busy, frame_done
    );

endinterface

// File: rtl/idm_ctrl_sequencer_sched_rom.sv
// Combinational row -> control word lookup; lanes with a trivial twiddle (row 0 or lane 0) are bypassed.
module idm_sched_rom
    import idm_pkg::*;
(
    input  logic [2:0] row,
    output idm_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            logic [2:0] lane;
            lane = 3'(k);
            if (row == 3'd0 || lane == 3'd0) begin
                ctrl.bypass_en[lane]      = 1'b1;
                ctrl.bypass_sel[3*k +: 3] = IDM_BYP_PASS;
            end else begin
                ctrl.shuf[3*k +: 3]     = IDM_SCHED[row][lane].shuf;
                ctrl.type_sel[3*k +: 3] = IDM_SCHED[row][lane].type_sel;
                ctrl.deshuf[3*k +: 3]   = IDM_SCHED[row][lane].deshuf;
            end
        end
    end

endmodule

// File: rtl/idm_ctrl_sequencer.sv
// Row sequencer for the 64-point FFT interdimensional twiddle multiplier.
// Define IDM_SEQ_OUTREG_EN to use the multiplier's registered output path (adds a DRAIN cycle).
module idm_ctrl_sequencer
    import idm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    idm_ctrl_sequencer_if.slave  bus
);

    idm_state_e state;
    logic [2:0] row_idx;
    logic [2:0] rom_row;
    idm_ctrl_t  rom_ctrl;
    idm_ctrl_t  ctrl_q;
    logic       row_ready_q;
    logic       busy_q;
    logic       accept;
    logic       last_accept;

    assign accept      = bus.row_valid & row_ready_q;
    assign last_accept = accept & (row_idx == 3'(ROWS - 1));

    // Controls are preloaded one row ahead so they match the row being presented
    assign rom_row = (state == IDM_IDLE) ? 3'd0 : row_idx + 3'd1;

    idm_sched_rom u_rom (
        .row  (rom_row),
        .ctrl (rom_ctrl)
    );

`ifdef IDM_SEQ_OUTREG_EN
    localparam idm_state_e LAST_NEXT = IDM_DRAIN;

    logic out_valid_q;
    logic frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= accept;
            frame_done_q <= last_accept;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.hold_ctrl  = accept ? 8'h00 : 8'hFF;
    assign bus.dff_ctrl   = 8'hFF;
`else
    localparam idm_state_e LAST_NEXT = IDM_IDLE;

    assign bus.out_valid  = accept;
    assign bus.frame_done = last_accept;
    assign bus.hold_ctrl  = 8'hFF;
    assign bus.dff_ctrl   = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDM_IDLE;
            row_idx     <= '0;
            ctrl_q      <= '0;
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDM_IDLE: begin
                    if (bus.start) begin
                        state       <= IDM_RUN;
                        row_idx     <= '0;
                        ctrl_q      <= rom_ctrl;
                        row_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                IDM_RUN: begin
                    if (last_accept) begin
                        state       <= LAST_NEXT;
                        row_idx     <= '0;
                        ctrl_q      <= '0;
                        row_ready_q <= 1'b0;
                        busy_q      <= (LAST_NEXT != IDM_IDLE);
                    end else if (accept) begin
                        row_idx <= row_idx + 3'd1;
                        ctrl_q  <= rom_ctrl;
                    end
                end
                IDM_DRAIN: begin
                    state  <= IDM_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state       <= IDM_IDLE;
                    row_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.row_ready   = row_ready_q;
    assign bus.busy        = busy_q;
    assign bus.row_idx     = row_idx;
    assign bus.shuf_ctrl   = ctrl_q.shuf;
    assign bus.type_sel    = ctrl_q.type_sel;
    assign bus.bypass_sel  = ctrl_q.bypass_sel;
    assign bus.deshuf_ctrl = ctrl_q.deshuf;
    assign bus.bypass_en   = ctrl_q.bypass_en;

endmodule

// File: tb/tb_idm_ctrl_sequencer.sv
// Scoreboard bench for idm_ctrl_sequencer: twiddle controls from r*k arithmetic, outputs matched per accepted row.
module tb_idm_ctrl_sequencer;
    import idm_pkg::*;

`ifdef IDM_SEQ_OUTREG_EN
    localparam bit OUTREG = 1'b1;
`else
    localparam bit OUTREG = 1'b0;
`endif
    localparam int LAT = OUTREG ? 1 : 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic row_valid = 1'b0;

    always #5 clk = ~clk;

    idm_ctrl_sequencer_if sif ();
    assign sif.start     = start;
    assign sif.row_valid = row_valid;

    idm_ctrl_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int row;
        int due;
    } sb_t;
    sb_t sb [$];

    // Reference model: frame progress in terms of rows accepted
    bit m_run = 1'b0;
    bit m_drain = 1'b0;
    int m_row = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   <= 1'b0;
            m_drain <= 1'b0;
            m_row   <= 0;
        end else if (m_drain) begin
            m_drain <= 1'b0;
        end else if (m_run) begin
            if (row_valid) begin
                if (m_row == 7) begin
                    m_run   <= 1'b0;
                    m_row   <= 0;
                    m_drain <= OUTREG;
                end else begin
                    m_row <= m_row + 1;
                end
            end
        end else if (start) begin
            m_run <= 1'b1;
            m_row <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Twiddle W64^(r*k): octant (r*k)/8 selects de-shuffle, (r*k)%8 the fine multiplier type
    function automatic void exp_ctrl(input int r, input bit act,
                                     output logic [23:0] sh, output logic [23:0] ty,
                                     output logic [23:0] bs, output logic [23:0] ds,
                                     output logic [7:0] be);
        sh = '0; ty = '0; bs = '0; ds = '0; be = '0;
        if (act) begin
            for (int k = 0; k < 8; k++) begin
                int e;
                e = r * k;
                if (r == 0 || k == 0) begin
                    be[k] = 1'b1;
                    bs[3*k +: 3] = IDM_BYP_PASS;
                end else begin
                    sh[3*k +: 3] = 3'(k);
                    ty[3*k +: 3] = 3'(e % 8);
                    ds[3*k +: 3] = 3'(e / 8);
                end
            end
        end
    endfunction

    always @(negedge clk) begin : monitor
        logic [23:0] sh, ty, bs, ds;
        logic [7:0] be;
        sb_t it;
        exp_ctrl(m_row, m_run, sh, ty, bs, ds, be);
        chk("row_ready", 32'(sif.row_ready), 32'(m_run));
        chk("busy", 32'(sif.busy), 32'(m_run || m_drain));
        chk("row_idx", 32'(sif.row_idx), 32'(m_row));
        chk("shuf_ctrl", 32'(sif.shuf_ctrl), 32'(sh));
        chk("type_sel", 32'(sif.type_sel), 32'(ty));
        chk("bypass_sel", 32'(sif.bypass_sel), 32'(bs));
        chk("deshuf_ctrl", 32'(sif.deshuf_ctrl), 32'(ds));
        chk("bypass_en", 32'(sif.bypass_en), 32'(be));
        chk("dff_ctrl", 32'(sif.dff_ctrl), OUTREG ? 32'hFF : 32'h00);
        chk("hold_ctrl", 32'(sif.hold_ctrl), (OUTREG && m_run && row_valid) ? 32'h00 : 32'hFF);
        if (sif.out_valid) begin
            if (sb.size() == 0) begin
                chk("out_valid_spurious", 32'(sif.out_valid), 32'd0);
            end else begin
                it = sb.pop_front();
                chk("out_latency", 32'(cyc), 32'(it.due));
                chk("frame_done", 32'(sif.frame_done), 32'(it.row == 7));
            end
        end else begin
            chk("frame_done_idle", 32'(sif.frame_done), 32'd0);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("out_valid_missing", 32'(sif.out_valid), 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            row_valid = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        row_valid = 1'b0;
    endtask

    // mode 0: row_valid held high; 1: 4-cycle stall after row 2; 2: random valid and stray starts
    task automatic run_frame(input int mode, input int rst_at);
        int t0, len, stalls, st_left;
        bit rv, aborted;
        len = 0; stalls = 0; st_left = 4; aborted = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        row_valid = 1'($urandom_range(0, 1));
        t0 = cyc;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (!sif.busy) begin
                len = cyc - t0;
                break;
            end
            if (rst_at >= 0 && m_run && m_row == rst_at) begin
                row_valid = 1'b0;
                rst_n = 1'b0;
                sb.delete();
                aborted = 1'b1;
                #1;
                chk("async_rst_busy", 32'(sif.busy), 32'd0);
                chk("async_rst_ready", 32'(sif.row_ready), 32'd0);
                chk("async_rst_row_idx", 32'(sif.row_idx), 32'd0);
                chk("async_rst_bypass_en", 32'(sif.bypass_en), 32'd0);
                chk("async_rst_frame_done", 32'(sif.frame_done), 32'd0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end
            case (mode)
                0: rv = 1'b1;
                1: rv = !(m_row == 3 && st_left > 0);
                default: rv = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 1 && m_run && !rv) st_left--;
            if (mode == 2 && m_run) start = ($urandom_range(0, 5) == 0);
            row_valid = rv;
            if (m_run && !rv) stalls++;
            if (m_run && rv) sb.push_back('{row: m_row, due: cyc + LAT});
        end
        if (!aborted) chk("frame_len", 32'(len), 32'(9 + stalls + LAT));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        run_frame(0, -1);
        idle(3);
        run_frame(1, -1);
        idle(2);
        run_frame(0, 5);
        idle(1);
        run_frame(0, -1);
        for (int i = 0; i < 25; i++) begin
            run_frame(2, -1);
            idle($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
